decode_stage: RTL
=================

# decode_stage

Parametrised, pipelined RISC-V instruction decoder sitting between fetch and execute. It accepts one instruction plus its PC per valid/ready handshake and reads source registers from the asynchronous-read register file. It registers a fully resolved operand set (operands, immediate, branch/jump target, class flags, illegal flag) into a one-entry output stage with backpressure and flush. It generalises the earlier fixed RV32I decoder to XLEN 32/64 and optional M extension, computes PC-relative targets, and detects illegal encodings.

## Interface
- XLEN, 32: datapath width; 32 or 64 (64 enables OP-32/OP-IMM-32, LD/SD/LWU, 6-bit shamt).
- ENABLE_M, 0: 1 accepts funct7=0000001 on OP (and OP-32) as legal MUL/DIV.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- in_valid / in_ready  in / out  1  upstream handshake; in_ready = !out_valid || out_ready.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard held and incoming instruction.
- raddr1, raddr2  out  5  in_instr[19:15], [24:20]; 0 while reset.
- rdata1, rdata2  in  XLEN  register values for raddr1/2, same cycle.
- out_valid / out_ready  out / in  1  downstream handshake.
- out_pc  out  XLEN  captured PC.
- operand_a, operand_b, store_data, imm, target  out  XLEN  see Operation.
- dest  out  5  rd; forced 0 for store, branch, fence, illegal.
- func3  out  3; func7  out  7  raw fields.
- is_alu, is_load, is_store, is_branch, is_jump, is_reg, is_word, is_misc, is_system, illegal  out  1 each.

## Operation
- Capture when in_valid && in_ready && !flush. Decode is combinational from in_instr/rdata; all outputs are registers.
- Immediates sign-extended to XLEN. Per opcode:
  - OP: a=rs1, b=rs2, is_alu.
  - OP-IMM: a=rs1, b=I-imm; shifts: b=shamt zero-extended (5 bits XLEN=32, 6 bits XLEN=64), is_alu.
  - LOAD: a=rs1, b=I-imm, is_load.
  - STORE: a=rs1, b=S-imm, store_data=rs2, is_store.
  - BRANCH: a=rs1, b=rs2, target=pc+B-imm, is_branch.
  - JAL: a=pc, b=4, target=pc+J-imm, is_jump.
  - JALR: a=pc, b=4, target=(rs1+I-imm)&~1, is_jump, is_reg.
  - LUI: a=0, b=U-imm, is_alu. AUIPC: a=pc, b=U-imm, is_alu.
  - FENCE: is_misc. SYSTEM: a=rs1, b=I-imm, is_system.
  - OP-32/OP-IMM-32 (XLEN=64 only): as OP/OP-IMM, plus is_word.
- imm carries the format's immediate; 0 for R-type.
- illegal=1 with all class flags 0 when any of:
  - in_instr[1:0]≠11; unknown opcode (including W opcodes at XLEN=32);
  - OP funct7 ∉ {0000000, 0100000, 0000001 if ENABLE_M}; 0100000 only with func3 000/101;
  - shift funct7 (funct6 at XLEN=64) not 0/0100000 (SRAI only on 101); RV32 shamt[5]=1;
  - LOAD func3 ∈ {011 (XLEN=32), 110 (XLEN=32), 111}; STORE func3 ≥ 100 (≥ 011 at XLEN=32);
  - BRANCH func3 ∈ {010, 011}; JALR func3 ≠ 000.
- Illegal instructions still travel downstream with out_valid=1, out_pc valid; downstream traps.

## Timing
- Latency 1: instruction captured at edge N is presented from N+1.
- Hold: out_valid && !out_ready keeps every output stable; in_ready=0.
- Same-cycle drain and capture: out_ready=1 and in_valid=1 replace the entry, giving full throughput.
- flush: out_valid=0 next edge; a simultaneous input is dropped. in_ready may be 1 during flush.
- reset: all outputs 0 (out_valid=0, in_ready=1 after release). Mid-operation reset discards the held entry.
- raddr1/2 combinational; rdata must be stable by the capturing edge. No forwarding here.

## Structure
- decode_pkg: opcode localparams, funct3/funct7 constants, XLEN-legal checks, class-flag struct.
- Sub-module imm_gen: combinational; in instr, XLEN param; out I/S/B/U/J immediates. Everything else in decode_stage.

## Test plan
- 0xFFF10093 (addi x1,x2,-1), rdata1=5 -> next cycle out_valid, is_alu, a=5, b=0xFFFFFFFF, dest=1, raddr1=2.
- 0x00312423 (sw x3,8(x2)), rdata1=0x1000, rdata2=0xAB -> is_store, a=0x1000, b=8, store_data=0xAB, dest=0.
- 0x008000EF (jal x1,+8) at pc=0x100 -> is_jump, target=0x108, a=0x100, b=4, dest=1. 0x123452B7 (lui x5) -> b=0x12345000, a=0.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0; release -> next instruction appears one cycle later, none lost or duplicated.
- 0xFFFFFFFF, then 0x0000007B -> both illegal=1, flags 0. XLEN=32 with 0x0000101B (OP-IMM-32) -> illegal; XLEN=64 -> is_word.
- flush with held entry and in_valid=1 -> out_valid=0 next cycle. Reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcode and field constants, class flags and
// encoding legality helpers shared by the decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_MISC    = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_reg;
    logic is_word;
    logic is_misc;
    logic is_system;
  } class_t;

  function automatic logic op_ok(
    input logic [6:0] f7,
    input logic [2:0] f3,
    input logic       m
  );
    return (f7 == F7_BASE)
        || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))
        || (m && f7 == F7_MULDIV);
  endfunction

  // wide: 6-bit shamt, so only funct6 is an opcode field
  function automatic logic shift_ok(
    input logic       wide,
    input logic [6:0] f7,
    input logic [2:0] f3
  );
    if (wide)
      return (f7[6:1] == 6'b000000)
          || (f7[6:1] == 6'b010000 && f3 == F3_SR);
    return (f7 == F7_BASE)
        || (f7 == F7_ALT && f3 == F3_SR);
  endfunction

  function automatic logic load_ok(
    input logic       rv64,
    input logic [2:0] f3
  );
    if (f3 == 3'b111)
      return 1'b0;
    return rv64 || (f3 != 3'b011 && f3 != 3'b110);
  endfunction

  function automatic logic store_ok(
    input logic       rv64,
    input logic [2:0] f3
  );
    return rv64 ? (f3 < 3'b100) : (f3 < 3'b011);
  endfunction

  function automatic logic branch_ok(
    input logic [2:0] f3
  );
    return f3 != 3'b010 && f3 != 3'b011;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediates of one
// instruction word, widened to XLEN.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  assign imm_i = XLEN'(signed'(instr[31:20]));
  assign imm_s = XLEN'(signed'({instr[31:25],
                                instr[11:7]}));
  assign imm_b = XLEN'(signed'({instr[31], instr[7],
                                instr[30:25], instr[11:8],
                                1'b0}));
  assign imm_u = XLEN'(signed'({instr[31:12], 12'b0}));
  assign imm_j = XLEN'(signed'({instr[31], instr[19:12],
                                instr[20], instr[30:21],
                                1'b0}));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32/RV64 decoder with register-file read and a
// one-entry registered output slot (backpressure, flush).
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            is_alu,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_word,
  output logic            is_misc,
  output logic            is_system,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    class_t          cls;
    logic            ill;
  } entry_t;

  logic            valid_q;
  logic            valid_d;
  entry_t          ent_q;
  entry_t          ent_d;
  entry_t          dec;
  logic            ok;
  logic [5:0]      sh6;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign raddr1 = reset ? 5'd0 : in_instr[19:15];
  assign raddr2 = reset ? 5'd0 : in_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    dec.rd = in_instr[11:7];
    dec.f3 = f3;
    dec.f7 = f7;
    ok     = 1'b1;
    // word shifts keep a 5-bit shamt even on RV64
    sh6 = (RV64 && opc == OPC_OPIMM) ? in_instr[25:20]
                                     : {1'b0, in_instr[24:20]};
    unique case (1'b1)
      (opc == OPC_OP),
      (RV64 && opc == OPC_OP32): begin
        ok  = op_ok(f7, f3, ENABLE_M);
        dec.a = rdata1;
        dec.b = rdata2;
        dec.cls.is_alu  = 1'b1;
        dec.cls.is_word = (opc == OPC_OP32);
      end
      (opc == OPC_OPIMM),
      (RV64 && opc == OPC_OPIMM32): begin
        dec.a   = rdata1;
        dec.b   = imm_i;
        dec.imm = imm_i;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          ok    = shift_ok(RV64 && opc == OPC_OPIMM, f7, f3);
          dec.b = XLEN'(sh6);
        end
        dec.cls.is_alu  = 1'b1;
        dec.cls.is_word = (opc == OPC_OPIMM32);
      end
      (opc == OPC_LOAD): begin
        ok      = load_ok(RV64, f3);
        dec.a   = rdata1;
        dec.b   = imm_i;
        dec.imm = imm_i;
        dec.cls.is_load = 1'b1;
      end
      (opc == OPC_STORE): begin
        ok      = store_ok(RV64, f3);
        dec.a   = rdata1;
        dec.b   = imm_s;
        dec.sd  = rdata2;
        dec.imm = imm_s;
        dec.rd  = '0;
        dec.cls.is_store = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        ok      = branch_ok(f3);
        dec.a   = rdata1;
        dec.b   = rdata2;
        dec.imm = imm_b;
        dec.tgt = in_pc + imm_b;
        dec.rd  = '0;
        dec.cls.is_branch = 1'b1;
      end
      (opc == OPC_JAL): begin
        dec.a   = in_pc;
        dec.b   = XLEN'(4);
        dec.imm = imm_j;
        dec.tgt = in_pc + imm_j;
        dec.cls.is_jump = 1'b1;
      end
      (opc == OPC_JALR): begin
        ok      = (f3 == 3'b000);
        dec.a   = in_pc;
        dec.b   = XLEN'(4);
        dec.imm = imm_i;
        dec.tgt = (rdata1 + imm_i) & ~XLEN'(1);
        dec.cls.is_jump = 1'b1;
        dec.cls.is_reg  = 1'b1;
      end
      (opc == OPC_LUI): begin
        dec.b   = imm_u;
        dec.imm = imm_u;
        dec.cls.is_alu = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        dec.a   = in_pc;
        dec.b   = imm_u;
        dec.imm = imm_u;
        dec.cls.is_alu = 1'b1;
      end
      (opc == OPC_MISC): begin
        dec.imm = imm_i;
        dec.rd  = '0;
        dec.cls.is_misc = 1'b1;
      end
      (opc == OPC_SYSTEM): begin
        dec.a   = rdata1;
        dec.b   = imm_i;
        dec.imm = imm_i;
        dec.cls.is_system = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    // illegal words keep only pc and raw fields for the trap
    if (!ok) begin
      dec     = '0;
      dec.pc  = in_pc;
      dec.f3  = f3;
      dec.f7  = f7;
      dec.ill = 1'b1;
    end
  end

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      ent_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = ent_q.pc;
  assign operand_a  = ent_q.a;
  assign operand_b  = ent_q.b;
  assign store_data = ent_q.sd;
  assign imm        = ent_q.imm;
  assign target     = ent_q.tgt;
  assign dest       = ent_q.rd;
  assign func3      = ent_q.f3;
  assign func7      = ent_q.f7;
  assign is_alu     = ent_q.cls.is_alu;
  assign is_load    = ent_q.cls.is_load;
  assign is_store   = ent_q.cls.is_store;
  assign is_branch  = ent_q.cls.is_branch;
  assign is_jump    = ent_q.cls.is_jump;
  assign is_reg     = ent_q.cls.is_reg;
  assign is_word    = ent_q.cls.is_word;
  assign is_misc    = ent_q.cls.is_misc;
  assign is_system  = ent_q.cls.is_system;
  assign illegal    = ent_q.ill;

endmodule
